// File: rtl/fdct_d1_serial.sv
// Forward 1-D 8-point DCT (AAN flow graph, 8-bit fractional constants).
// Serial sample load, one-cycle row transform, serial unscaled coefficient emit.
// Optional macro FDCT_LEVEL_SHIFT_EN: treat in_d[7:0] as an unsigned pixel and
// store it level-shifted by -128.
//
// state | meaning
// LOAD  | accepting samples into d[0..7]
// CALC  | one cycle: transform d into c[0..7]
// EMIT  | presenting c[out_cnt] on out_d until the index-7 transfer
module fdct_d1_serial #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_d,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int W = IN_W + 12;

    typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

    state_t state, state_nxt;
    logic [2:0] in_cnt, out_cnt;
    logic ready_en;
    logic in_fire, out_fire;
    logic signed [IN_W-1:0]  sample;
    logic signed [IN_W-1:0]  d      [8];
    logic signed [OUT_W-1:0] c      [8];
    logic signed [OUT_W-1:0] c_calc [8];

    logic signed [W-1:0] x [8];
    logic signed [W-1:0] t0, t1, t2, t3, t4, t5, t6, t7;
    logic signed [W-1:0] e10, e11, e12, e13, z1;
    logic signed [W-1:0] o10, o11, o12, z2, z3, z4, z5, z11, z13;

`ifdef FDCT_LEVEL_SHIFT_EN
    logic signed [8:0] pix_shift;
    assign pix_shift = $signed({1'b0, in_d[7:0]}) - 9'sd128;
    assign sample    = IN_W'(pix_shift);
`else
    assign sample = $signed(in_d);
`endif

    // Multiply by an 8-bit fractional constant, floor (arithmetic) shift back.
    function automatic logic signed [W-1:0] mulk(input logic signed [W-1:0] a,
                                                 input logic signed [10:0] k);
        logic signed [W+10:0] p;
        p = (W+11)'(a) * (W+11)'(k);
        return W'(p >>> 8);
    endfunction

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state <= LOAD;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_fire && in_cnt == 3'd7) state_nxt = CALC;
            CALC:    state_nxt = EMIT;
            EMIT:    if (out_fire && out_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Input-side handshake; ready is held off for the cycle after reset releases.
    always_comb begin
        in_ready = (state == LOAD) && ready_en && reset;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    // Combinational AAN flow graph over the buffered row.
    always_comb begin
        for (int i = 0; i < 8; i++) x[i] = W'(d[i]);
        t0 = x[0] + x[7];  t7 = x[0] - x[7];
        t1 = x[1] + x[6];  t6 = x[1] - x[6];
        t2 = x[2] + x[5];  t5 = x[2] - x[5];
        t3 = x[3] + x[4];  t4 = x[3] - x[4];
        e10 = t0 + t3;  e13 = t0 - t3;
        e11 = t1 + t2;  e12 = t1 - t2;
        z1  = mulk(e12 + e13, 11'sd181);
        o10 = t4 + t5;  o11 = t5 + t6;  o12 = t6 + t7;
        z5  = mulk(o10 - o12, 11'sd98);
        z2  = mulk(o10, 11'sd139) + z5;
        z4  = mulk(o12, 11'sd334) + z5;
        z3  = mulk(o11, 11'sd181);
        z11 = t7 + z3;
        z13 = t7 - z3;
        c_calc[0] = OUT_W'(e10 + e11);
        c_calc[4] = OUT_W'(e10 - e11);
        c_calc[2] = OUT_W'(e13 + z1);
        c_calc[6] = OUT_W'(e13 - z1);
        c_calc[5] = OUT_W'(z13 + z2);
        c_calc[3] = OUT_W'(z13 - z2);
        c_calc[1] = OUT_W'(z11 + z4);
        c_calc[7] = OUT_W'(z11 - z4);
    end

    // Row and coefficient storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (in_fire) d[in_cnt] <= sample;
        if (state == CALC) begin
            for (int i = 0; i < 8; i++) c[i] <= c_calc[i];
        end
    end

    // Counters and registered output stage.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ready_en  <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_d     <= '0;
        end else begin
            ready_en <= 1'b1;
            if (in_fire) in_cnt <= in_cnt + 3'd1;
            if (state == CALC) begin
                out_d     <= c_calc[0];
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                out_cnt   <= '0;
            end else if (state == EMIT && out_fire) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_cnt   <= '0;
                end else begin
                    out_cnt  <= out_cnt + 3'd1;
                    out_d    <= c[out_cnt + 3'd1];
                    out_last <= (out_cnt == 3'd6);
                end
            end
        end
    end

endmodule

// File: tb/tb_fdct_d1_serial.sv
// Self-checking bench for fdct_d1_serial: table of directed rows plus
// hand-written reset / backpressure sequences and a few model-checked rows.
module tb_fdct_d1_serial;

    localparam int IN_W  = 9;
    localparam int OUT_W = 16;
    localparam int NV    = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [IN_W-1:0]  in_d = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] out_d;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;

    fdct_d1_serial #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clock(clock), .reset(reset),
        .in_d(in_d), .in_valid(in_valid), .in_ready(in_ready),
        .out_d(out_d), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clock = ~clock;

    typedef logic [7:0][15:0] row_t;
    typedef struct packed {
        row_t din;
        row_t dout;
    } vec_t;

    vec_t  tbl [NV];
    string names [NV];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] raw_of(input int v);
`ifdef FDCT_LEVEL_SHIFT_EN
        return 16'(v + 128);
`else
        return 16'(v);
`endif
    endfunction

    function automatic void ref_dct(input int d[8], output int c[8]);
        int t0, t1, t2, t3, t4, t5, t6, t7;
        int e10, e11, e12, e13, z1, o10, o11, o12, z2, z3, z4, z5, z11, z13;
        t0 = d[0] + d[7]; t7 = d[0] - d[7];
        t1 = d[1] + d[6]; t6 = d[1] - d[6];
        t2 = d[2] + d[5]; t5 = d[2] - d[5];
        t3 = d[3] + d[4]; t4 = d[3] - d[4];
        e10 = t0 + t3; e13 = t0 - t3; e11 = t1 + t2; e12 = t1 - t2;
        c[0] = e10 + e11; c[4] = e10 - e11;
        z1 = ((e12 + e13) * 181) >>> 8;
        c[2] = e13 + z1; c[6] = e13 - z1;
        o10 = t4 + t5; o11 = t5 + t6; o12 = t6 + t7;
        z5 = ((o10 - o12) * 98) >>> 8;
        z2 = ((o10 * 139) >>> 8) + z5;
        z4 = ((o12 * 334) >>> 8) + z5;
        z3 = (o11 * 181) >>> 8;
        z11 = t7 + z3; z13 = t7 - z3;
        c[5] = z13 + z2; c[3] = z13 - z2; c[1] = z11 + z4; c[7] = z11 - z4;
    endfunction

    task automatic send_row(input row_t row);
        int budget;
        for (int i = 0; i < 8; i++) begin
            in_d = IN_W'(row[i]);
            in_valid = 1'b1;
            budget = 0;
            while (in_ready !== 1'b1 && budget < 100) begin
                @(posedge clock); #1;
                budget++;
            end
            if (budget >= 100) chk("in_ready_timeout", 0, 1);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    // pattern 0: out_ready always high; pattern 1: high one cycle in three.
    task automatic recv_row(input int pattern, output row_t got,
                            output logic [7:0] lasts, output int n);
        int cyc;
        int hd, hl;
        bit held;
        cyc = 0; held = 0; n = 0; hd = 0; hl = 0;
        got = '0; lasts = '0;
        while (n < 8 && cyc < 200) begin
            out_ready = (pattern == 0) || (cyc % 3 == 0);
            if (held) begin
                chk("stall_out_d", int'(out_d), hd);
                chk("stall_out_last", int'(out_last), hl);
                held = 0;
            end
            if (out_valid === 1'b1) begin
                if (pattern == 1) chk("in_ready_during_emit", int'(in_ready), 0);
                if (out_ready) begin
                    got[n] = out_d;
                    lasts[n] = out_last;
                    n++;
                end else begin
                    held = 1;
                    hd = int'(out_d);
                    hl = int'(out_last);
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (n < 8) chk("recv_timeout", n, 8);
    endtask

    task automatic check_row(input string tag, input row_t got,
                             input logic [7:0] lasts, input int exp[8]);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_c%0d", tag, i), int'($signed(got[i])), exp[i]);
            chk($sformatf("%s_last%0d", tag, i), int'(lasts[i]), (i == 7) ? 1 : 0);
        end
    endtask

    task automatic no_extra(input string tag);
        int extra;
        extra = 0;
        repeat (5) begin
            if (out_valid === 1'b1) extra++;
            @(posedge clock); #1;
        end
        chk(tag, extra, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t       got, row;
        logic [7:0] lasts;
        int         n, budget;
        int         exp[8], dd[8];
        int         imp[8] = '{64, 122, 109, 89, 64, 39, 19, 6};

        // ---- vector table ----
`ifdef FDCT_LEVEL_SHIFT_EN
        names = '{"ls228", "ls128", "ls0", "ls228_hi"};
        for (int i = 0; i < 8; i++) begin
            tbl[0].din[i] = 16'd228;   tbl[0].dout[i] = (i == 0) ? 16'd800 : 16'd0;
            tbl[1].din[i] = 16'd128;   tbl[1].dout[i] = 16'd0;
            tbl[2].din[i] = 16'd0;     tbl[2].dout[i] = (i == 0) ? 16'(-1024) : 16'd0;
            tbl[3].din[i] = 16'h01E4;  tbl[3].dout[i] = (i == 0) ? 16'd800 : 16'd0;
        end
`else
        names = '{"dc100", "impulse", "alt_ext", "dc_neg50"};
        for (int i = 0; i < 8; i++) begin
            tbl[0].din[i] = 16'd100;
            tbl[0].dout[i] = (i == 0) ? 16'd800 : 16'd0;
            tbl[1].din[i] = (i == 0) ? 16'd64 : 16'd0;
            tbl[1].dout[i] = 16'(imp[i]);
            tbl[2].din[i] = (i % 2 == 0) ? 16'(-256) : 16'd255;
            tbl[2].dout[i] = (i == 0) ? 16'(-4) : ((i % 2 == 1) ? 16'(-511) : 16'd0);
            tbl[3].din[i] = 16'(-50);
            tbl[3].dout[i] = (i == 0) ? 16'(-400) : 16'd0;
        end
`endif

        // ---- reset state ----
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_d", int'(out_d), 0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // ---- table rows at full output rate, with latency checks ----
        for (int v = 0; v < NV; v++) begin
            send_row(tbl[v].din);
            chk({names[v], "_calc_valid"}, int'(out_valid), 0);
            chk({names[v], "_calc_ready"}, int'(in_ready), 0);
            @(posedge clock); #1;
            chk({names[v], "_first_valid"}, int'(out_valid), 1);
            recv_row(0, got, lasts, n);
            for (int i = 0; i < 8; i++) exp[i] = int'($signed(tbl[v].dout[i]));
            check_row(names[v], got, lasts, exp);
            chk({names[v], "_ready_after"}, int'(in_ready), 1);
            no_extra({names[v], "_no_extra"});
        end

        // ---- backpressure on a DC row ----
        for (int i = 0; i < 8; i++) row[i] = raw_of(100);
        send_row(row);
        recv_row(1, got, lasts, n);
        chk("bp_transfers", n, 8);
        for (int i = 0; i < 8; i++) exp[i] = (i == 0) ? 800 : 0;
        check_row("bp", got, lasts, exp);
        chk("bp_ready_after", int'(in_ready), 1);
        chk("bp_valid_after", int'(out_valid), 0);

        // ---- reset in the middle of a partial row ----
        for (int i = 0; i < 5; i++) begin
            in_d = IN_W'(raw_of(7));
            in_valid = 1'b1;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("midrow_rst_ready", int'(in_ready), 0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrow_ready_back", int'(in_ready), 1);
        for (int i = 0; i < 8; i++) row[i] = raw_of(-50);
        send_row(row);
        recv_row(0, got, lasts, n);
        for (int i = 0; i < 8; i++) exp[i] = (i == 0) ? -400 : 0;
        check_row("midrow", got, lasts, exp);
        no_extra("midrow_no_extra");

        // ---- reset during emit at out_cnt==3 ----
        for (int i = 0; i < 8; i++) row[i] = raw_of((i == 0) ? 64 : 0);
        send_row(row);
        budget = 0;
        while (out_valid !== 1'b1 && budget < 20) begin
            @(posedge clock); #1;
            budget++;
        end
        if (budget >= 20) chk("emit_wait_timeout", 0, 1);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        chk("emit3_out_d", int'($signed(out_d)), 89);
        out_ready = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("emit_rst_valid", int'(out_valid), 0);
        chk("emit_rst_out_d", int'(out_d), 0);
        chk("emit_rst_last", int'(out_last), 0);
        reset = 1'b1;
        out_ready = 1'b1;
        no_extra("emit_rst_no_extra");
        out_ready = 1'b0;
        chk("emit_rst_ready", int'(in_ready), 1);

        // ---- model-checked random rows ----
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
`ifdef FDCT_LEVEL_SHIFT_EN
                dd[i] = int'($urandom_range(0, 255)) - 128;
`else
                dd[i] = int'($urandom_range(0, 511)) - 256;
`endif
                row[i] = raw_of(dd[i]);
            end
            ref_dct(dd, exp);
            send_row(row);
            recv_row(0, got, lasts, n);
            check_row($sformatf("rand%0d", r), got, lasts, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
